// File: rtl/knight_anim_pkg.sv
// Shared types and constants for the knight sprite animation controller.
package knight_anim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_VERT   = 2'd2,
    ST_ATTACK = 2'd3
  } anim_state_t;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_J = 8'h0D;

  localparam int RUN_FRAMES_DEF   = 4;
  localparam int ATK_FRAMES_DEF   = 3;
  localparam int FRAME_HOLD_DEF   = 6;
  localparam int ATK_COOLDOWN_DEF = 12;

endpackage

// File: rtl/anim_stepper.sv
// Hold/frame counter pair: each frame is held FRAME_HOLD edges, the frame
// index wraps after num_frames, and last_done flags the final advance.
module anim_stepper #(
  parameter int FRAME_HOLD = 6
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [3:0] num_frames,
  output logic [2:0] frame_idx,
  output logic       advance,
  output logic       last_done
);

  localparam int HW = $clog2(FRAME_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(FRAME_HOLD - 1);

  logic [HW-1:0] hold;
  logic          at_last;

  assign advance   = enable && (hold == HOLD_MAX);
  assign at_last   = ({1'b0, frame_idx} == (num_frames - 4'd1));
  assign last_done = advance && at_last;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      hold      <= '0;
      frame_idx <= '0;
    end else if (clear || !enable) begin
      hold      <= '0;
      frame_idx <= '0;
    end else if (advance) begin
      hold      <= '0;
      frame_idx <= at_last ? 3'd0 : frame_idx + 3'd1;
    end else begin
      hold      <= hold + 1'b1;
    end
  end

endmodule

// File: rtl/knight_anim_fsm.sv
// Knight animation controller: derives animation state, frame, facing and
// attack timing from player motion and the raw keycode, one step per frame.
module knight_anim_fsm
  import knight_anim_pkg::*;
#(
  parameter int RUN_FRAMES   = RUN_FRAMES_DEF,
  parameter int ATK_FRAMES   = ATK_FRAMES_DEF,
  parameter int FRAME_HOLD   = FRAME_HOLD_DEF,
  parameter int ATK_COOLDOWN = ATK_COOLDOWN_DEF
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  output logic [1:0] anim_state,
  output logic [2:0] frame_idx,
  output logic       facing_left,
  output logic       attack_active,
  output logic       hit_pulse
);

  localparam int CW = (ATK_COOLDOWN < 1) ? 1 : $clog2(ATK_COOLDOWN + 1);
  // The exit edge itself counts as the first cooldown edge, so the first
  // re-triggerable edge lands exactly ATK_COOLDOWN edges after exit.
  localparam logic [CW-1:0] CD_LOAD = (ATK_COOLDOWN > 0) ? CW'(ATK_COOLDOWN - 1) : '0;

  anim_state_t   state, state_nxt, motion_state;
  logic [9:0]    prev_x, prev_y;
  logic [7:0]    prev_key;
  logic          primed;
  logic [CW-1:0] cooldown, cooldown_nxt;
  logic          moving_x, moving_y, atk_req;
  logic          step_clear, step_en, step_adv, last_done;
  logic [3:0]    num_frames;

  always_comb begin
    moving_x     = primed && (BallX != prev_x);
    moving_y     = primed && (BallY != prev_y);
    atk_req      = (keycode == KEY_J) && (prev_key != KEY_J) &&
                   (cooldown == '0) && (state != ST_ATTACK);
    motion_state = moving_y ? ST_VERT : (moving_x ? ST_RUN : ST_IDLE);
    state_nxt    = motion_state;
    cooldown_nxt = cooldown;
    if (state == ST_ATTACK) begin
      if (last_done) begin
        state_nxt    = motion_state;
        cooldown_nxt = CD_LOAD;
      end else begin
        state_nxt    = ST_ATTACK;
      end
    end else begin
      if (atk_req) state_nxt = ST_ATTACK;
      if (cooldown != '0) cooldown_nxt = cooldown - 1'b1;
    end
    step_en    = (state == ST_RUN) || (state == ST_ATTACK);
    step_clear = (state_nxt != state);
    num_frames = (state == ST_ATTACK) ? 4'(ATK_FRAMES) : 4'(RUN_FRAMES);
  end

  anim_stepper #(
    .FRAME_HOLD (FRAME_HOLD)
  ) u_stepper (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .clear      (step_clear),
    .enable     (step_en),
    .num_frames (num_frames),
    .frame_idx  (frame_idx),
    .advance    (step_adv),
    .last_done  (last_done)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state         <= ST_IDLE;
      prev_x        <= '0;
      prev_y        <= '0;
      prev_key      <= '0;
      primed        <= 1'b0;
      cooldown      <= '0;
      facing_left   <= 1'b0;
      attack_active <= 1'b0;
      hit_pulse     <= 1'b0;
    end else begin
      state         <= state_nxt;
      prev_x        <= BallX;
      prev_y        <= BallY;
      prev_key      <= keycode;
      primed        <= 1'b1;
      cooldown      <= cooldown_nxt;
      attack_active <= (state_nxt == ST_ATTACK);
      hit_pulse     <= (state == ST_ATTACK) && step_adv && (frame_idx == 3'd0);
      if (state != ST_ATTACK) begin
        if (keycode == KEY_A)      facing_left <= 1'b1;
        else if (keycode == KEY_D) facing_left <= 1'b0;
      end
    end
  end

  assign anim_state = state;

endmodule

// File: tb/tb_knight_anim_fsm.sv
// Directed bench for knight_anim_fsm with an age-based reference model.
module tb_knight_anim_fsm;
  import knight_anim_pkg::*;

  localparam int RF = 4;
  localparam int AF = 3;
  localparam int FH = 6;
  localparam int CD = 12;

  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] BallX = 10'd100;
  logic [9:0] BallY = 10'd200;
  logic [1:0] anim_state;
  logic [2:0] frame_idx;
  logic       facing_left, attack_active, hit_pulse;

  knight_anim_fsm #(
    .RUN_FRAMES(RF), .ATK_FRAMES(AF), .FRAME_HOLD(FH), .ATK_COOLDOWN(CD)
  ) dut (
    .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .BallX(BallX), .BallY(BallY), .anim_state(anim_state),
    .frame_idx(frame_idx), .facing_left(facing_left),
    .attack_active(attack_active), .hit_pulse(hit_pulse)
  );

  always #5 frame_clk = ~frame_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state plus the number of edges spent in it ("age").
  int m_st = 0, m_age = 0, m_cd = 0, m_face = 0, m_hit = 0;
  int m_primed = 0, m_px = 0, m_py = 0, m_pk = 0;

  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      m_st = 0; m_age = 0; m_cd = 0; m_face = 0; m_hit = 0;
      m_primed = 0; m_px = 0; m_py = 0; m_pk = 0;
    end else begin
      int k, x, y, mov_st, nst;
      k = keycode; x = BallX; y = BallY;
      mov_st = (m_primed && y != m_py) ? 2 : ((m_primed && x != m_px) ? 1 : 0);
      if (m_st == 3) begin
        if (m_age + 1 == AF * FH) begin
          nst = mov_st;
          m_cd = CD - 1;
        end else nst = 3;
      end else begin
        nst = (k == KEY_J && m_pk != KEY_J && m_cd == 0) ? 3 : mov_st;
        if (m_cd > 0) m_cd--;
      end
      m_hit = (m_st == 3 && nst == 3 && m_age + 1 == FH) ? 1 : 0;
      if (m_st != 3) begin
        if (k == KEY_A) m_face = 1;
        else if (k == KEY_D) m_face = 0;
      end
      m_age = (nst != m_st) ? 0 : m_age + 1;
      m_st = nst;
      m_primed = 1; m_px = x; m_py = y; m_pk = k;
    end
  end

  function automatic int m_frame();
    if (m_st == 1) return (m_age / FH) % RF;
    if (m_st == 3) return m_age / FH;
    return 0;
  endfunction

  always @(negedge frame_clk) begin
    check("anim_state", anim_state, m_st);
    check("frame_idx", frame_idx, m_frame());
    check("facing_left", facing_left, m_face);
    check("attack_active", attack_active, (m_st == 3) ? 1 : 0);
    check("hit_pulse", hit_pulse, m_hit);
  end

  task automatic tick(input logic [7:0] k, input logic [9:0] x, input logic [9:0] y);
    keycode = k; BallX = x; BallY = y;
    @(posedge frame_clk);
    #1;
  endtask

  initial begin
    logic [9:0] x, y;
    x = 10'd100; y = 10'd200;

    repeat (3) @(posedge frame_clk);
    #1;
    check("rst_state", anim_state, 0);
    check("rst_frame", frame_idx, 0);
    check("rst_hit", hit_pulse, 0);
    Reset = 1'b0;

    repeat (10) tick(8'h00, x, y);
    check("idle_state", anim_state, 0);
    check("idle_facing", facing_left, 0);

    for (int i = 1; i <= 30; i++) begin
      x = x + 10'd1;
      tick(8'h00, x, y);
      if (i == 1)  check("run_entry", anim_state, 1);
      if (i == 19) check("run_frame3", frame_idx, 3);
      if (i == 25) check("run_wrap", frame_idx, 0);
    end
    tick(8'h00, x, y);
    check("run_stop", anim_state, 0);

    for (int i = 1; i <= 40; i++) begin
      tick(KEY_J, x, y);
      if (i == 1)  check("atk_entry", anim_state, 3);
      if (i == 7)  check("atk_hit", hit_pulse, 1);
      if (i == 7)  check("atk_frame1", frame_idx, 1);
      if (i == 8)  check("atk_hit_drop", hit_pulse, 0);
      if (i == 13) check("atk_frame2", frame_idx, 2);
      if (i == 19) check("atk_exit", anim_state, 0);
      if (i == 40) check("atk_held_no_retrig", attack_active, 0);
    end
    tick(8'h00, x, y);

    tick(KEY_J, x, y);
    repeat (18) tick(8'h00, x, y);
    check("atk2_exit", anim_state, 0);
    for (int k = 1; k <= 12; k++) begin
      tick((k == 5 || k == 12) ? KEY_J : 8'h00, x, y);
      if (k == 5)  check("cooldown_block", anim_state, 0);
      if (k == 12) check("cooldown_retrig", anim_state, 3);
    end
    repeat (18) tick(8'h00, x, y);
    check("atk3_exit", anim_state, 0);

    x = x + 10'd1; y = y + 10'd1;
    tick(8'h00, x, y);
    check("diag_vert", anim_state, 2);
    check("diag_frame", frame_idx, 0);
    tick(8'h00, x, y);
    repeat (10) tick(8'h00, x, y);

    tick(KEY_J, x, y);
    for (int i = 1; i <= 19; i++) begin
      tick(KEY_A, x, y);
      if (i == 17) check("face_frozen", facing_left, 0);
      if (i == 18) check("face_exit_edge", facing_left, 0);
      if (i == 19) check("face_after_exit", facing_left, 1);
    end

    repeat (12) tick(8'h00, x, y);
    tick(KEY_J, x, y);
    repeat (6) tick(8'h00, x, y);
    check("pre_rst_frame", frame_idx, 1);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_state", anim_state, 0);
    check("async_rst_frame", frame_idx, 0);
    check("async_rst_active", attack_active, 0);
    check("async_rst_facing", facing_left, 0);
    tick(8'h00, x, y);
    Reset = 1'b0;
    tick(KEY_J, x, y);
    check("post_rst_attack", anim_state, 3);
    repeat (3) tick(8'h00, x, y);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
